// File: rtl/cpc_vram_pkg.sv
// Shared constants and helpers for the CPC video-RAM fetch path.
package cpc_vram_pkg;

  localparam int CPC_VRAM_AW   = 15;
  // Widest VRAM word the byte-extract helper accepts, in bytes.
  localparam int CPC_MAX_BYTES = 16;

  // Byte k of a VRAM word; out-of-range k yields zero.
  function automatic logic [7:0] cpc_get_byte(input logic [8*CPC_MAX_BYTES-1:0] word,
                                               input int k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < CPC_MAX_BYTES; i++)
      if (i == k) r = word[8*i +: 8];
    return r;
  endfunction

  // CRTC MA/RA to VRAM word address: MA[11:10] and RA[4:3] are not wired.
  function automatic logic [CPC_VRAM_AW-1:0] cpc_vram_addr(input logic [13:0] ma,
                                                           input logic [4:0]  ra);
    return {ma[13:12], ra[2:0], ma[9:0]};
  endfunction

endpackage

// File: rtl/cpc_vram_fetch_if.sv
// Timing/VRAM side bundle of the fetch unit.
interface cpc_vram_fetch_if #(
  parameter int BYTES     = 2,
  parameter int SHIFT_MAX = 1
);
  localparam int SW = $clog2(SHIFT_MAX + 1);

  logic                 cpu_n;
  logic                 ras_n;
  logic                 cas_n;
  logic [13:0]          crtc_ma;
  logic [4:0]           crtc_ra;
  logic                 crtc_de;
  logic [SW-1:0]        shift_cnt;
  logic [8*BYTES-1:0]   vram_din;
  logic [14:0]          vram_addr;
  logic [7:0]           vram_d;
  logic                 byte_stb;
  logic                 overrun;

  // Gate Array / CRTC / SDRAM side.
  modport master (
    output cpu_n, ras_n, cas_n, crtc_ma, crtc_ra, crtc_de, shift_cnt, vram_din,
    input  vram_addr, vram_d, byte_stb, overrun
  );

  // Fetch unit side.
  modport slave (
    input  cpu_n, ras_n, cas_n, crtc_ma, crtc_ra, crtc_de, shift_cnt, vram_din,
    output vram_addr, vram_d, byte_stb, overrun
  );
endinterface

// File: rtl/cpc_byte_delay.sv
// SHIFT_MAX-deep byte delay line: push with blank mask, tap at a selected depth.
module cpc_byte_delay #(
  parameter int SHIFT_MAX = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           mask,
  input  logic [7:0]                     din,
  input  logic [$clog2(SHIFT_MAX+1)-1:0] sel,
  output logic [7:0]                     tap
);
  logic [SHIFT_MAX-1:0][7:0] dl_q, dl_d;

  // Shift on push; blanked bytes enter as zero.
  always_comb begin
    dl_d = dl_q;
    if (push) begin
      dl_d[0] = mask ? din : 8'h00;
      for (int i = 1; i < SHIFT_MAX; i++) dl_d[i] = dl_q[i-1];
    end
  end

  // Tap sel (1..SHIFT_MAX) returns the entry pushed sel bytes ago.
  always_comb begin
    tap = 8'h00;
    for (int i = 0; i < SHIFT_MAX; i++)
      if (int'(sel) == i + 1) tap = dl_q[i];
  end

  // Delay line register.
  always_ff @(posedge clk or posedge rst)
    if (rst) dl_q <= '0;
    else     dl_q <= dl_d;

endmodule

// File: rtl/cpc_vram_fetch.sv
// VRAM fetch: address mapping, per-slot byte index, strobe, overrun and delayed byte output.
module cpc_vram_fetch
  import cpc_vram_pkg::*;
#(
  parameter int BYTES     = 2,
  parameter int SHIFT_MAX = 1
) (
  input logic            clk,
  input logic            reset,
  cpc_vram_fetch_if.slave bus
);
  localparam int IW = $clog2(BYTES);
  localparam int SW = $clog2(SHIFT_MAX + 1);

  logic                   cas_n_q, cas_n_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   full_q, full_d;     // last byte of this slot already fetched
  logic                   overrun_q, overrun_d;
  logic                   byte_stb_q, byte_stb_d;
  logic [CPC_VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]             vram_d_q, vram_d_d;

  logic                   stb, push;
  logic [SW-1:0]          s_eff;
  logic [8*CPC_MAX_BYTES-1:0] word_ext;
  logic [7:0]             cur_byte, live_byte, tap;

  // Strobe, clamped shift and byte selection from the current word.
  always_comb begin
    stb   = !bus.ras_n && !cas_n_q && bus.cas_n;
    push  = stb && bus.cpu_n;
    s_eff = (int'(bus.shift_cnt) > SHIFT_MAX) ? SW'(SHIFT_MAX) : bus.shift_cnt;
    word_ext = '0;
    word_ext[8*BYTES-1:0] = bus.vram_din;
    cur_byte  = cpc_get_byte(word_ext, int'(idx_q));
    live_byte = cpc_get_byte(word_ext, int'(idx_q) - int'(s_eff));
  end

  cpc_byte_delay #(.SHIFT_MAX(SHIFT_MAX)) u_dly (
    .clk  (clk),
    .rst  (reset),
    .push (push),
    .mask (bus.crtc_de),
    .din  (cur_byte),
    .sel  (s_eff),
    .tap  (tap)
  );

  // Next-state: index/overrun per slot, address tracking, byte output mux.
  always_comb begin
    cas_n_d     = bus.cas_n;
    byte_stb_d  = stb;
    idx_d       = idx_q;
    full_d      = full_q;
    overrun_d   = overrun_q;
    vram_addr_d = vram_addr_q;
    vram_d_d    = vram_d_q;

    if (!bus.cpu_n) begin
      idx_d  = '0;
      full_d = 1'b0;
    end else begin
      vram_addr_d = cpc_vram_addr(bus.crtc_ma, bus.crtc_ra);
      if (stb) begin
        if (full_q)                           overrun_d = 1'b1;
        else if (idx_q == IW'(BYTES - 1))     full_d    = 1'b1;
        else                                  idx_d     = idx_q + IW'(1);
      end
    end

    // The line shifts on every byte, so the byte S positions back sits at depth S-1.
    if (bus.cpu_n && !bus.ras_n && !bus.cas_n) begin
      if (s_eff == '0)                        vram_d_d = cur_byte;
      else if (int'(idx_q) >= int'(s_eff))   vram_d_d = live_byte;
      else                                    vram_d_d = tap;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cas_n_q     <= 1'b1;
      idx_q       <= '0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      byte_stb_q  <= 1'b0;
      vram_addr_q <= '0;
      vram_d_q    <= '0;
    end else begin
      cas_n_q     <= cas_n_d;
      idx_q       <= idx_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      byte_stb_q  <= byte_stb_d;
      vram_addr_q <= vram_addr_d;
      vram_d_q    <= vram_d_d;
    end

  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_d    = vram_d_q;
  assign bus.byte_stb  = byte_stb_q;
  assign bus.overrun   = overrun_q;

endmodule
